vector_uop_sequencer: RTL



---
 rtl/vector_uop_sequencer_if.sv | 70 +++++++
 rtl/vector_uop_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_uop_sequencer_if.sv
// Instruction-in / micro-op-out bundle between decode, the uop sequencer and vector_lane.
// The slave modport is the sequencer side; the master modport is the decode/lane side.
// Widths follow the lane datapath parameters of the attached vector_lane.
interface vector_uop_sequencer_if #(
  parameter int LANES_DATA_WIDTH = 64,
  parameter int MICROOP_BIT      = 9
);
  localparam int MASK_W = LANES_DATA_WIDTH / 8;

  // control and instruction handshake
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [MICROOP_BIT-1:0]      in_alu_op;
  logic [4:0]                  in_vs1;
  logic [4:0]                  in_vs2;
  logic [4:0]                  in_vd;
  logic [1:0]                  in_lmul;
  logic [1:0]                  in_op1_sel;
  logic                        in_masked;
  logic                        in_load;
  logic                        in_store;
  logic                        in_indexed;
  logic                        in_wb_en;
  logic                        in_mult;
  logic [LANES_DATA_WIDTH-1:0] in_immediate;
  logic [LANES_DATA_WIDTH-1:0] in_scalar;
  logic [2:0]                  in_sew;

  // lane side
  logic [LANES_DATA_WIDTH-1:0] vector_mask;
  logic                        stall;
  logic [MICROOP_BIT-1:0]      alu_op;
  logic [4:0]                  operand_1;
  logic [4:0]                  operand_2;
  logic [4:0]                  destination;
  logic [MASK_W-1:0]           mask_bits;
  logic                        masked_operation;
  logic                        load_operation;
  logic                        store_operation;
  logic                        indexed_memory_operation;
  logic                        write_back_enable;
  logic                        multiplication_flag;
  logic [LANES_DATA_WIDTH-1:0] operand_1_immediate;
  logic [LANES_DATA_WIDTH-1:0] operand_1_scalar;
  logic [2:0]                  sew_out;
  logic                        uop_valid;
  logic                        busy;
  logic                        instr_done;

  modport slave (
    input  flush, in_valid, in_alu_op, in_vs1, in_vs2, in_vd, in_lmul, in_op1_sel,
           in_masked, in_load, in_store, in_indexed, in_wb_en, in_mult,
           in_immediate, in_scalar, in_sew, vector_mask, stall,
    output in_ready, alu_op, operand_1, operand_2, destination, mask_bits,
           masked_operation, load_operation, store_operation, indexed_memory_operation,
           write_back_enable, multiplication_flag, operand_1_immediate, operand_1_scalar,
           sew_out, uop_valid, busy, instr_done
  );

  modport master (
    output flush, in_valid, in_alu_op, in_vs1, in_vs2, in_vd, in_lmul, in_op1_sel,
           in_masked, in_load, in_store, in_indexed, in_wb_en, in_mult,
           in_immediate, in_scalar, in_sew, vector_mask, stall,
    input  in_ready, alu_op, operand_1, operand_2, destination, mask_bits,
           masked_operation, load_operation, store_operation, indexed_memory_operation,
           write_back_enable, multiplication_flag, operand_1_immediate, operand_1_scalar,
           sew_out, uop_valid, busy, instr_done
  );
endinterface

// File: rtl/vector_uop_sequencer.sv
// Expands one vector instruction into 1/2/4/8 lane micro-ops (one per group register).
// Latency: first micro-op registered one cycle after acceptance, then one per cycle.
// Backpressure: stall freezes all outputs; in_ready allows back-to-back with no bubble.
module vector_uop_sequencer #(
  parameter int LANES_DATA_WIDTH = 64,
  parameter int MICROOP_BIT      = 9
) (
  input logic clk,
  input logic rst,
  vector_uop_sequencer_if.slave bus
);
  localparam int W  = LANES_DATA_WIDTH;
  localparam int MB = LANES_DATA_WIDTH / 8;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [MICROOP_BIT-1:0] alu_op;
    logic [4:0]             vs1;
    logic [4:0]             vs2;
    logic [4:0]             vd;
    logic [1:0]             lmul;
    logic [1:0]             op1_sel;
    logic                   masked;
    logic                   load;
    logic                   store;
    logic                   indexed;
    logic                   wb_en;
    logic                   mult;
    logic [W-1:0]           immediate;
    logic [W-1:0]           scalar;
    logic [2:0]             sew;
  } instr_t;

  typedef struct packed {
    logic [MICROOP_BIT-1:0] alu_op;
    logic [4:0]             operand_1;
    logic [4:0]             operand_2;
    logic [4:0]             destination;
    logic [MB-1:0]          mask_bits;
    logic                   masked_operation;
    logic                   load_operation;
    logic                   store_operation;
    logic                   indexed_memory_operation;
    logic                   write_back_enable;
    logic                   multiplication_flag;
    logic [W-1:0]           immediate;
    logic [W-1:0]           scalar;
    logic [2:0]             sew;
  } uop_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  instr_t     instr, instr_nxt, in_instr;
  uop_t       uop, uop_nxt;
  logic       uop_valid, valid_nxt;
  logic       instr_done, done_nxt;
  logic       last, fire, ready, accept;

  // index of the final micro-op of a register group
  function automatic logic [2:0] group_last(input logic [1:0] lmul);
    case (lmul)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // micro-op i of an instruction; register indices wrap modulo 32
  function automatic uop_t make_uop(input instr_t ins, input logic [2:0] i,
                                    input logic [W-1:0] mask);
    uop_t u;
    u = '0;
    u.alu_op      = ins.alu_op;
    // scalar/immediate sources keep vs1 fixed; selector 3 behaves as vector
    u.operand_1   = (ins.op1_sel == 2'd1 || ins.op1_sel == 2'd2) ? ins.vs1
                                                                 : ins.vs1 + {2'b00, i};
    u.operand_2   = ins.vs2 + {2'b00, i};
    u.destination = ins.vd + {2'b00, i};
    u.mask_bits   = ins.masked ? MB'(mask >> (int'(i) * MB)) : '1;
    u.masked_operation         = ins.masked;
    u.load_operation           = ins.load;
    u.store_operation          = ins.store;
    u.indexed_memory_operation = ins.indexed;
    u.write_back_enable        = ins.wb_en;
    u.multiplication_flag      = ins.mult;
    u.immediate   = (ins.op1_sel == 2'd2) ? ins.immediate : '0;
    u.scalar      = (ins.op1_sel == 2'd1) ? ins.scalar : '0;
    u.sew         = ins.sew;
    return u;
  endfunction

  // bubble: data/register fields hold, flags drop
  function automatic uop_t clear_flags(input uop_t u);
    uop_t r;
    r = u;
    r.masked_operation         = 1'b0;
    r.load_operation           = 1'b0;
    r.store_operation          = 1'b0;
    r.indexed_memory_operation = 1'b0;
    r.write_back_enable        = 1'b0;
    r.multiplication_flag      = 1'b0;
    return r;
  endfunction

  // gather the incoming instruction fields
  always_comb begin
    in_instr.alu_op    = bus.in_alu_op;
    in_instr.vs1       = bus.in_vs1;
    in_instr.vs2       = bus.in_vs2;
    in_instr.vd        = bus.in_vd;
    in_instr.lmul      = bus.in_lmul;
    in_instr.op1_sel   = bus.in_op1_sel;
    in_instr.masked    = bus.in_masked;
    in_instr.load      = bus.in_load;
    in_instr.store     = bus.in_store;
    in_instr.indexed   = bus.in_indexed;
    in_instr.wb_en     = bus.in_wb_en;
    in_instr.mult      = bus.in_mult;
    in_instr.immediate = bus.in_immediate;
    in_instr.scalar    = bus.in_scalar;
    in_instr.sew       = bus.in_sew;
  end

  assign last   = (idx == group_last(instr.lmul));
  assign fire   = uop_valid && !bus.stall;
  assign ready  = !bus.flush && (state == IDLE || (fire && last));
  assign accept = bus.in_valid && ready;

  // state, counter, held instruction and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 3'd0;
      instr         <= '0;
      uop           <= '0;
      uop.mask_bits <= '1;
      uop_valid     <= 1'b0;
      instr_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      instr      <= instr_nxt;
      uop        <= uop_nxt;
      uop_valid  <= valid_nxt;
      instr_done <= done_nxt;
    end
  end

  // next state: flush beats acceptance, acceptance beats completion
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    instr_nxt = instr;
    if (bus.flush) begin
      state_nxt = IDLE;
      idx_nxt   = 3'd0;
    end else if (accept) begin
      state_nxt = ISSUE;
      idx_nxt   = 3'd0;
      instr_nxt = in_instr;
    end else if (fire) begin
      if (last) begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end else begin
        idx_nxt = idx + 3'd1;
      end
    end
  end

  // next micro-op outputs; a stalled live micro-op keeps everything as is
  always_comb begin
    uop_nxt   = uop;
    valid_nxt = uop_valid;
    done_nxt  = 1'b0;
    if (bus.flush) begin
      uop_nxt   = clear_flags(uop);
      valid_nxt = 1'b0;
    end else begin
      done_nxt = fire && last;
      if (accept) begin
        uop_nxt   = make_uop(in_instr, 3'd0, bus.vector_mask);
        valid_nxt = 1'b1;
      end else if (fire && !last) begin
        uop_nxt = make_uop(instr, idx + 3'd1, bus.vector_mask);
      end else if (fire) begin
        uop_nxt   = clear_flags(uop);
        valid_nxt = 1'b0;
      end
    end
  end

  assign bus.in_ready                 = ready;
  assign bus.alu_op                   = uop.alu_op;
  assign bus.operand_1                = uop.operand_1;
  assign bus.operand_2                = uop.operand_2;
  assign bus.destination              = uop.destination;
  assign bus.mask_bits                = uop.mask_bits;
  assign bus.masked_operation         = uop.masked_operation;
  assign bus.load_operation           = uop.load_operation;
  assign bus.store_operation          = uop.store_operation;
  assign bus.indexed_memory_operation = uop.indexed_memory_operation;
  assign bus.write_back_enable        = uop.write_back_enable;
  assign bus.multiplication_flag      = uop.multiplication_flag;
  assign bus.operand_1_immediate      = uop.immediate;
  assign bus.operand_1_scalar         = uop.scalar;
  assign bus.sew_out                  = uop.sew;
  assign bus.uop_valid                = uop_valid;
  assign bus.busy                     = (state == ISSUE);
  assign bus.instr_done               = instr_done;
endmodule
